// File: rtl/gate_test_pkg.sv
// Shared types and constants for the gate stimulus/response checker.
//   state_e      : sweep FSM states
//   num_vectors  : number of input vectors for an n-input gate
//   TRUTH_*      : ready-made truth tables for common 2-input gates
package gate_test_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  function automatic int num_vectors(input int n);
    return 1 << n;
  endfunction

  // Bit v is the expected gate output for input vector v.
  localparam logic [3:0] TRUTH_XOR2 = 4'b0110;
  localparam logic [3:0] TRUTH_AND2 = 4'b1000;
  localparam logic [3:0] TRUTH_OR2  = 4'b1110;

endpackage

// File: rtl/gate_stim_checker_settle_timer.sv
// settle_timer: counts the cycles a vector has been driven.
//   clk, rst_n : clock / async active-low reset
//   i_load     : clear the count (wins over i_en)
//   i_en       : advance the count while not yet expired
//   o_expire   : the current cycle is the last settle cycle
module settle_timer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  localparam int W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

  logic [W-1:0] r_cnt;
  logic         w_expire;

  assign w_expire = (r_cnt == W'(SETTLE_CYCLES - 1));
  assign o_expire = w_expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_cnt <= '0;
    else if (i_load)           r_cnt <= '0;
    // Stop at the terminal value; the FSM leaves DRIVE on expiry anyway.
    else if (i_en && !w_expire) r_cnt <= r_cnt + W'(1);
  end

endmodule

// File: rtl/gate_stim_checker.sv
// gate_stim_checker: sweeps every input vector into a combinational gate,
// holds each for SETTLE_CYCLES, samples the gate output for one cycle and
// compares it with TRUTH. Reports mismatch count, lowest failing vector and
// pass/fail.
//   clk, rst_n       : clock / async active-low reset
//   start            : begin a sweep (honoured only in IDLE or DONE)
//   abort            : back to IDLE from anywhere, results held
//   dut_o            : gate-under-test output
//   stim             : vector driven into the gate (bit0 toggles fastest)
//   sample_stb       : dut_o is checked this cycle
//   busy, done, pass : status; pass valid while done
//   err_count        : number of mismatching vectors
//   first_fail_vec   : lowest mismatching vector, first_fail_valid qualifies it
module gate_stim_checker
  import gate_test_pkg::*;
#(
  parameter int                          N_INPUTS      = 2,
  parameter logic [(1<<N_INPUTS)-1:0]    TRUTH         = TRUTH_XOR2,
  parameter int                          SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                dut_o,
  output logic [N_INPUTS-1:0] stim,
  output logic                sample_stb,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_INPUTS:0]   err_count,
  output logic [N_INPUTS-1:0] first_fail_vec,
  output logic                first_fail_valid
);

  state_e              r_state, w_nstate;
  logic [N_INPUTS-1:0] r_stim, w_nstim;
  logic [N_INPUTS:0]   r_err, w_nerr, w_err_upd;
  logic [N_INPUTS-1:0] r_ffv, w_nffv;
  logic                r_ffvld, w_nffvld;
  logic                r_pass, w_npass;
  logic                w_tload, w_ten, w_expire;
  logic                w_mismatch, w_last;

  settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_tload),
    .i_en     (w_ten),
    .o_expire (w_expire)
  );

  assign w_mismatch = (dut_o != TRUTH[r_stim]);
  assign w_last     = &r_stim;
  // Count including the sample being retired this cycle.
  assign w_err_upd  = r_err + (N_INPUTS+1)'(w_mismatch);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_stim  <= '0;
      r_err   <= '0;
      r_ffv   <= '0;
      r_ffvld <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_stim  <= w_nstim;
      r_err   <= w_nerr;
      r_ffv   <= w_nffv;
      r_ffvld <= w_nffvld;
      r_pass  <= w_npass;
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_nstim  = r_stim;
    w_nerr   = r_err;
    w_nffv   = r_ffv;
    w_nffvld = r_ffvld;
    w_npass  = r_pass;
    w_tload  = 1'b0;
    w_ten    = 1'b0;
    if (abort) begin
      // Results stay visible after an abort; only the sweep is dropped.
      w_nstate = IDLE;
      w_nstim  = '0;
      w_tload  = 1'b1;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            w_nstate = DRIVE;
            w_nstim  = '0;
            w_nerr   = '0;
            w_nffv   = '0;
            w_nffvld = 1'b0;
            w_npass  = 1'b0;
            w_tload  = 1'b1;
          end
        end
        DRIVE: begin
          w_ten = 1'b1;
          if (w_expire) w_nstate = SAMPLE;
        end
        SAMPLE: begin
          w_nerr = w_err_upd;
          if (w_mismatch && !r_ffvld) begin
            w_nffv   = r_stim;
            w_nffvld = 1'b1;
          end
          if (w_last) begin
            w_nstate = DONE;
            w_npass  = (w_err_upd == '0);
          end else begin
            w_nstate = DRIVE;
            w_nstim  = r_stim + N_INPUTS'(1);
            w_tload  = 1'b1;
          end
        end
        default: w_nstate = IDLE;
      endcase
    end
  end

  assign stim             = r_stim;
  assign sample_stb       = (r_state == SAMPLE);
  assign busy             = (r_state == DRIVE) || (r_state == SAMPLE);
  assign done             = (r_state == DONE);
  assign pass             = r_pass;
  assign err_count        = r_err;
  assign first_fail_vec   = r_ffv;
  assign first_fail_valid = r_ffvld;

endmodule

// File: tb/tb_gate_stim_checker.sv
// Bench for gate_stim_checker: two instances (settle 1 and settle 3) each
// driving a behavioural gate whose fault mode is selectable. A sweep-level
// model predicts every output on every cycle; directed steps add literal
// expectations for timing, results, abort and reset.
module tb_gate_stim_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0, abort0 = 1'b0, start3 = 1'b0, abort3 = 1'b0;
  logic dut_o0, dut_o3;

  logic [1:0] stim0, stim3;
  logic       stb0, stb3, busy0, busy3, done0, done3, pass0, pass3;
  logic [2:0] err0, err3;
  logic [1:0] ffv0, ffv3;
  logic       ffvld0, ffvld3;

  int vectors = 0;
  int miscompares = 0;

  // gate mode: 0 correct XOR, 1 stuck at 0, 2 XNOR
  int gm [2] = '{0, 0};
  int sv [2] = '{1, 3};
  logic [3:0] tt = 4'b0110;

  // model state: 0 idle, 1 sweeping, 2 done
  int mst [2] = '{0, 0};
  int mt  [2] = '{0, 0};
  int herr[2] = '{0, 0};
  int hffv[2] = '{0, 0};
  int hfvl[2] = '{0, 0};
  int hps [2] = '{0, 0};

  always #5 clk = ~clk;

  function automatic logic gate_fn(input int m, input logic [1:0] v);
    case (m)
      0:       return v[0] ^ v[1];
      1:       return 1'b0;
      default: return ~(v[0] ^ v[1]);
    endcase
  endfunction

  assign dut_o0 = gate_fn(gm[0], stim0);
  assign dut_o3 = gate_fn(gm[1], stim3);

  gate_stim_checker #(.N_INPUTS(2), .TRUTH(4'b0110), .SETTLE_CYCLES(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .dut_o(dut_o0),
    .stim(stim0), .sample_stb(stb0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_fail_vec(ffv0), .first_fail_valid(ffvld0));

  gate_stim_checker #(.N_INPUTS(2), .TRUTH(4'b0110), .SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .dut_o(dut_o3),
    .stim(stim3), .sample_stb(stb3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .first_fail_vec(ffv3), .first_fail_valid(ffvld3));

  // mismatches among the first nv vectors
  function automatic int cnt_mis(input int m, input int nv);
    int c = 0;
    for (int k = 0; k < nv; k++)
      if (gate_fn(m, 2'(k)) != tt[k]) c++;
    return c;
  endfunction

  function automatic int first_mis(input int m, input int nv);
    for (int k = 0; k < nv; k++)
      if (gate_fn(m, 2'(k)) != tt[k]) return k;
    return -1;
  endfunction

  task automatic snap(input int i, input int nv);
    int f;
    herr[i] = cnt_mis(gm[i], nv);
    f = first_mis(gm[i], nv);
    hfvl[i] = (f >= 0) ? 1 : 0;
    hffv[i] = (f >= 0) ? f : 0;
  endtask

  task automatic step(input int i, input logic st, input logic ab);
    int total = 4 * (sv[i] + 1);
    if (ab) begin
      if (mst[i] == 1) snap(i, mt[i] / (sv[i] + 1));
      mst[i] = 0;
    end else if (st && mst[i] != 1) begin
      mst[i] = 1; mt[i] = 0;
      herr[i] = 0; hffv[i] = 0; hfvl[i] = 0; hps[i] = 0;
    end else if (mst[i] == 1) begin
      mt[i]++;
      if (mt[i] == total) begin
        mst[i] = 2;
        snap(i, 4);
        hps[i] = (herr[i] == 0) ? 1 : 0;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mst[i] = 0; mt[i] = 0; herr[i] = 0; hffv[i] = 0; hfvl[i] = 0; hps[i] = 0;
      end
    end else begin
      step(0, start0, abort0);
      step(1, start3, abort3);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic cmp(input int i, input logic [1:0] st, input logic stb,
                     input logic bsy, input logic dn, input logic ps,
                     input logic [2:0] er, input logic [1:0] fv, input logic fvl);
    int est, estb, ebsy, edn, eps, eer, efv, efvl, nv, f;
    string p;
    p = (i == 0) ? "u0" : "u3";
    if (!rst_n) begin
      est = 0; estb = 0; ebsy = 0; edn = 0; eps = 0; eer = 0; efv = 0; efvl = 0;
    end else if (mst[i] == 1) begin
      nv   = mt[i] / (sv[i] + 1);
      est  = nv;
      estb = (mt[i] % (sv[i] + 1) == sv[i]) ? 1 : 0;
      ebsy = 1; edn = 0; eps = 0;
      eer  = cnt_mis(gm[i], nv);
      f    = first_mis(gm[i], nv);
      efvl = (f >= 0) ? 1 : 0;
      efv  = (f >= 0) ? f : 0;
    end else begin
      est  = (mst[i] == 2) ? 3 : 0;
      estb = 0; ebsy = 0;
      edn  = (mst[i] == 2) ? 1 : 0;
      eps  = hps[i]; eer = herr[i]; efv = hffv[i]; efvl = hfvl[i];
    end
    chk({p, ".stim"}, int'(st), est);
    chk({p, ".sample_stb"}, int'(stb), estb);
    chk({p, ".busy"}, int'(bsy), ebsy);
    chk({p, ".done"}, int'(dn), edn);
    chk({p, ".pass"}, int'(ps), eps);
    chk({p, ".err_count"}, int'(er), eer);
    chk({p, ".first_fail_vec"}, int'(fv), efv);
    chk({p, ".first_fail_valid"}, int'(fvl), efvl);
  endtask

  always @(negedge clk) begin
    cmp(0, stim0, stb0, busy0, done0, pass0, err0, ffv0, ffvld0);
    cmp(1, stim3, stb3, busy3, done3, pass3, err3, ffv3, ffvld3);
  end

  // leaves the bench 2 time units after the n-th rising edge
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    cyc(3);
    chk("reset_busy0", int'(busy0), 0);
    chk("reset_err0", int'(err0), 0);
    rst_n = 1'b1;
    cyc(2);

    // correct XOR, done exactly 8 edges after start
    start0 = 1'b1; cyc(1); start0 = 1'b0;
    cyc(7); chk("xor_done_early", int'(done0), 0);
    cyc(1); chk("xor_done", int'(done0), 1);
    chk("xor_pass", int'(pass0), 1);
    chk("xor_err", int'(err0), 0);
    chk("xor_ffvld", int'(ffvld0), 0);

    // stuck at 0: vectors 1 and 2 fail
    gm[0] = 1;
    start0 = 1'b1; cyc(1); start0 = 1'b0; cyc(8);
    chk("stuck_err", int'(err0), 2);
    chk("stuck_ffv", int'(ffv0), 1);
    chk("stuck_ffvld", int'(ffvld0), 1);
    chk("stuck_pass", int'(pass0), 0);

    // XNOR: every vector fails
    gm[0] = 2;
    start0 = 1'b1; cyc(1); start0 = 1'b0; cyc(8);
    chk("xnor_err", int'(err0), 4);
    chk("xnor_ffv", int'(ffv0), 0);
    chk("xnor_pass", int'(pass0), 0);

    // start re-pulsed during DRIVE of vector 2 is ignored
    gm[0] = 0;
    start0 = 1'b1; cyc(1); start0 = 1'b0; cyc(4);
    chk("repulse_stim", int'(stim0), 2);
    start0 = 1'b1; cyc(1); start0 = 1'b0;
    cyc(2); chk("repulse_done_early", int'(done0), 0);
    cyc(1); chk("repulse_done", int'(done0), 1);
    chk("repulse_pass", int'(pass0), 1);

    // abort during SAMPLE of vector 1
    start0 = 1'b1; cyc(1); start0 = 1'b0; cyc(3);
    chk("abort_in_sample", int'(stb0), 1);
    chk("abort_sample_vec", int'(stim0), 1);
    abort0 = 1'b1; cyc(1); abort0 = 1'b0;
    chk("abort_stim", int'(stim0), 0);
    chk("abort_done", int'(done0), 0);
    chk("abort_busy", int'(busy0), 0);
    cyc(2); chk("abort_idle", int'(busy0), 0);
    start0 = 1'b1; cyc(1); start0 = 1'b0; cyc(8);
    chk("post_abort_done", int'(done0), 1);
    chk("post_abort_pass", int'(pass0), 1);

    // settle 3: done 16 edges after start
    start3 = 1'b1; cyc(1); start3 = 1'b0;
    cyc(15); chk("s3_done_early", int'(done3), 0);
    cyc(1); chk("s3_done", int'(done3), 1);
    chk("s3_pass", int'(pass3), 1);

    // async reset mid-sweep
    start3 = 1'b1; cyc(1); start3 = 1'b0; cyc(4);
    chk("s3_mid_stim", int'(stim3), 1);
    chk("s3_mid_busy", int'(busy3), 1);
    rst_n = 1'b0; #1;
    chk("rst_stim3", int'(stim3), 0);
    chk("rst_busy3", int'(busy3), 0);
    chk("rst_done0", int'(done0), 0);
    chk("rst_pass0", int'(pass0), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    chk("rst_idle_busy3", int'(busy3), 0);
    chk("rst_idle_done3", int'(done3), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
